uc_engine_outq: RTL and testbench
=================================

Name: uc_engine_outq

Overview:
- Per-engine output queue for newly derived unit-clause literals. It sits between one BCP engine and the unit-clause arbiter wrapper.
- It accepts literals from the engine and suppresses duplicates. It detects complementary pairs (lit and -lit both pending) as a local conflict.
- It presents a first-word-fall-through head (min/valid/empty) to the arbiter, which pops it.
- One instance per engine; the `NUM_ENGINE` instances form the eng2uca_min/valid/empty buses.

Parameters:
- DEPTH, 8, number of queue entries; power of two, >=2.
- LIT_W, $clog2(`UC_LENGTH), signed literal width; positive = variable true, negative = variable false, 0 = invalid.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- eng_push  input  1  engine offers a literal this cycle.
- eng_lit  input  signed LIT_W  literal offered.
- eng_full  output  1  queue full; the engine must not push while high.
- flush  input  1  synchronous clear of all state (backtrack/restart).
- uca_pop  input  1  arbiter consumed the head this cycle.
- eng2uca_min  output  signed LIT_W  head literal.
- eng2uca_valid  output  1  head literal valid.
- eng2uca_empty  output  1  queue empty.
- local_conflict  output  1  sticky complementary-literal flag.
- dup_drop  output  1  one-cycle pulse: the push this cycle was dropped as a duplicate.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - Pointers and count = 0; all entry valid bits = 0.
  - local_conflict = 0, dup_drop = 0, eng_full = 0.
  - eng2uca_empty = 1, eng2uca_valid = 0, eng2uca_min = 0.
  - Reset mid-operation discards all pending literals.
- Storage: circular buffer of DEPTH entries, each {valid, lit}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy 0..DEPTH.
- Head (combinational, first-word fall-through):
  - eng2uca_empty = (count==0).
  - eng2uca_valid = !empty.
  - eng2uca_min = entry[rd_ptr].lit when !empty, else 0.
- eng_full = (count==DEPTH), registered from count.
- Pop: when uca_pop && !empty, clear entry[rd_ptr].valid, advance rd_ptr, and decrement count on the next edge. A pop while empty is ignored.
- Push qualification, each evaluated against the entries valid at the start of the cycle, including the head being popped this cycle:
  - eng_lit==0: ignored; no state change, no dup_drop.
  - Duplicate (some valid entry lit == eng_lit): dropped; dup_drop=1 next cycle, occupancy unchanged.
  - Complement (some valid entry lit == -eng_lit): the literal is still enqueued if space exists. local_conflict is set next cycle and stays set until flush or reset.
  - Full (count==DEPTH) and no simultaneous pop: the push is dropped. This is a protocol violation; an assertion fires and no flag is raised.
  - Full with a simultaneous valid pop: the push is accepted and count is unchanged.
  - Otherwise: write entry[wr_ptr] = {1, eng_lit}, advance wr_ptr, increment count.
- Simultaneous push and pop with count in 1..DEPTH-1: both occur; count is unchanged.
- Push into an empty queue: the literal appears on eng2uca_min one cycle later (registered write). Push-to-head latency is 1 cycle.
- flush:
  - Highest priority; overrides push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, all valid=0, local_conflict=0, dup_drop=0.
- Width rules:
  - Negation is two's complement in LIT_W bits.
  - The most-negative value is never a legal literal; the engine guarantees this and an assertion checks it.
  - Comparisons are full-width signed equality.

Test Plan:
- Reset then push 5, 7, -3 on consecutive cycles with no pop:
  - count goes 1, 2, 3.
  - eng2uca_min=5 and valid=1 one cycle after the first push.
  - Popping three times yields 5, 7, -3, then empty=1, min=0.
- Duplicate push: push 9, then 9 again → the second push gives a dup_drop pulse, count stays 1, and one pop empties the queue.
- Complement: push 4 then -4 → count=2 and local_conflict=1 from the cycle after the second push. It stays 1 through pops; flush clears it next cycle.
- Full / wrap:
  - With DEPTH=8, push literals 1..8 → eng_full=1.
  - Push 10 plus a simultaneous pop → accepted, head=2, count=8.
  - Drain 8 pops → order 2..8, 10, correct across the pointer wrap.
- Flush priority: with 3 entries queued, assert flush, push 6 and pop together → next cycle count=0, empty=1, and 6 is not stored.
- Async reset mid-stream: with 4 entries and local_conflict=1, assert rst between clock edges → outputs go to their reset values immediately, without waiting for a clock edge. After release, push 2 → head=2, count=1.

Source files
------------

// File: rtl/uc_engine_outq.sv
// Per-engine unit-clause output queue: FWFT circular buffer with duplicate
// suppression and complementary-literal (local conflict) detection.
module uc_engine_outq #(
    parameter int DEPTH = 8,
    parameter int LIT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           eng_push,
    input  logic signed [LIT_W-1:0]        eng_lit,
    output logic                           eng_full,
    input  logic                           flush,
    input  logic                           uca_pop,
    output logic signed [LIT_W-1:0]        eng2uca_min,
    output logic                           eng2uca_valid,
    output logic                           eng2uca_empty,
    output logic                           local_conflict,
    output logic                           dup_drop,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic signed [LIT_W-1:0] MOST_NEG = {1'b1, {(LIT_W-1){1'b0}}};

    // Entries live in flops, not RAM: every slot is compared against each push.
    logic signed [LIT_W-1:0] lit_reg [DEPTH];
    logic [DEPTH-1:0]        valid_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        count_next;
    logic                    eng_full_reg;
    logic                    dup_drop_reg;
    logic                    conflict_reg;

    logic signed [LIT_W-1:0] neg_lit;
    logic [DEPTH-1:0]        dup_hit;
    logic [DEPTH-1:0]        comp_hit;
    logic                    is_empty;
    logic                    is_full;
    logic                    push_req;
    logic                    do_pop;
    logic                    do_push;

    assign neg_lit = -eng_lit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign dup_hit[gi]  = valid_reg[gi] && (lit_reg[gi] == eng_lit);
            assign comp_hit[gi] = valid_reg[gi] && (lit_reg[gi] == neg_lit);
        end
    endgenerate

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == FULL_COUNT);
    assign push_req = eng_push && (eng_lit != '0);
    assign do_pop   = uca_pop && !is_empty;
    // A full queue can still accept when the head leaves in the same cycle.
    assign do_push  = push_req && !(|dup_hit) && (!is_full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            eng_full_reg <= 1'b0;
            dup_drop_reg <= 1'b0;
            conflict_reg <= 1'b0;
        end else if (flush) begin
            valid_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            eng_full_reg <= 1'b0;
            dup_drop_reg <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            // Clear-then-set ordering lets a write land on the slot being popped.
            if (do_pop) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            end
            if (do_push) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            end
            count_reg    <= count_next;
            eng_full_reg <= (count_next == FULL_COUNT);
            dup_drop_reg <= push_req && (|dup_hit);
            if (push_req && (|comp_hit))
                conflict_reg <= 1'b1;
        end
    end

    // Literal payload needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!flush && do_push)
            lit_reg[wr_ptr_reg] <= eng_lit;
    end

    assign eng2uca_empty  = is_empty;
    assign eng2uca_valid  = !is_empty;
    assign eng2uca_min    = is_empty ? '0 : lit_reg[rd_ptr_reg];
    assign eng_full       = eng_full_reg;
    assign dup_drop       = dup_drop_reg;
    assign local_conflict = conflict_reg;
    assign count          = count_reg;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst || flush)
        !(push_req && is_full && !uca_pop));

    a_no_most_negative: assert property (@(posedge clk) disable iff (rst)
        !(eng_push && (eng_lit == MOST_NEG)));

endmodule

// File: tb/tb_uc_engine_outq.sv
// Directed bench for uc_engine_outq: ordering, duplicates, conflicts, wrap, flush, async reset.
module tb_uc_engine_outq;

    localparam int DEPTH = 8;
    localparam int LIT_W = 8;

    logic                    clk;
    logic                    rst;
    logic                    eng_push;
    logic signed [LIT_W-1:0] eng_lit;
    logic                    eng_full;
    logic                    flush;
    logic                    uca_pop;
    logic signed [LIT_W-1:0] eng2uca_min;
    logic                    eng2uca_valid;
    logic                    eng2uca_empty;
    logic                    local_conflict;
    logic                    dup_drop;
    logic [$clog2(DEPTH):0]  count;

    int errors = 0;
    int checks = 0;

    uc_engine_outq #(.DEPTH(DEPTH), .LIT_W(LIT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .eng_push       (eng_push),
        .eng_lit        (eng_lit),
        .eng_full       (eng_full),
        .flush          (flush),
        .uca_pop        (uca_pop),
        .eng2uca_min    (eng2uca_min),
        .eng2uca_valid  (eng2uca_valid),
        .eng2uca_empty  (eng2uca_empty),
        .local_conflict (local_conflict),
        .dup_drop       (dup_drop),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Apply one cycle of inputs at posedge+1, let the edge happen, return at next posedge+1.
    task automatic step(input logic push, input int lit, input logic pop, input logic fl);
        eng_push = push;
        eng_lit  = LIT_W'(lit);
        uca_pop  = pop;
        flush    = fl;
        @(posedge clk);
        #1;
        eng_push = 1'b0;
        eng_lit  = '0;
        uca_pop  = 1'b0;
        flush    = 1'b0;
    endtask

    int drain_exp [9] = '{2, 3, 4, 5, 6, 7, 8, 10, 0};

    initial begin
        rst      = 1'b1;
        eng_push = 1'b0;
        eng_lit  = '0;
        flush    = 1'b0;
        uca_pop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(eng2uca_empty), 1);
        check("reset_valid", int'(eng2uca_valid), 0);
        check("reset_min", int'(eng2uca_min), 0);
        check("reset_full", int'(eng_full), 0);
        check("reset_conflict", int'(local_conflict), 0);
        check("reset_dup", int'(dup_drop), 0);
        rst = 1'b0;

        // Basic ordering and push-to-head latency
        step(1, 5, 0, 0);
        check("p5_count", int'(count), 1);
        check("p5_min", int'(eng2uca_min), 5);
        check("p5_valid", int'(eng2uca_valid), 1);
        step(1, 7, 0, 0);
        check("p7_count", int'(count), 2);
        step(1, -3, 0, 0);
        check("pm3_count", int'(count), 3);
        check("pm3_min", int'(eng2uca_min), 5);
        check("pm3_conflict", int'(local_conflict), 0);
        step(0, 0, 1, 0);
        check("pop1_min", int'(eng2uca_min), 7);
        step(0, 0, 1, 0);
        check("pop2_min", int'(eng2uca_min), -3);
        step(0, 0, 1, 0);
        check("pop3_empty", int'(eng2uca_empty), 1);
        check("pop3_min", int'(eng2uca_min), 0);
        step(0, 0, 1, 0);
        check("pop_empty_count", int'(count), 0);

        // Duplicate suppression
        step(1, 9, 0, 0);
        check("dup_first_dup", int'(dup_drop), 0);
        step(1, 9, 0, 0);
        check("dup_pulse", int'(dup_drop), 1);
        check("dup_count", int'(count), 1);
        step(0, 0, 0, 0);
        check("dup_pulse_end", int'(dup_drop), 0);
        step(1, 0, 0, 0);
        check("zero_lit_count", int'(count), 1);
        step(0, 0, 1, 0);
        check("dup_pop_empty", int'(eng2uca_empty), 1);

        // Complementary pair
        step(1, 4, 0, 0);
        step(1, -4, 0, 0);
        check("comp_count", int'(count), 2);
        check("comp_conflict", int'(local_conflict), 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("comp_sticky", int'(local_conflict), 1);
        check("comp_drained", int'(eng2uca_empty), 1);
        step(0, 0, 0, 1);
        check("comp_flush_clr", int'(local_conflict), 0);

        // Fill, push-with-pop at full, wraparound drain
        for (int i = 1; i <= DEPTH; i++) step(1, i, 0, 0);
        check("fill_full", int'(eng_full), 1);
        check("fill_count", int'(count), 8);
        step(1, 10, 1, 0);
        check("fullpp_count", int'(count), 8);
        check("fullpp_min", int'(eng2uca_min), 2);
        check("fullpp_full", int'(eng_full), 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_min", i), int'(eng2uca_min), drain_exp[i]);
            step(0, 0, 1, 0);
        end
        check("drain_empty", int'(eng2uca_empty), 1);
        check("drain_full", int'(eng_full), 0);

        // Flush beats simultaneous push and pop
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        check("pre_flush_count", int'(count), 3);
        step(1, 6, 1, 1);
        check("flush_count", int'(count), 0);
        check("flush_empty", int'(eng2uca_empty), 1);
        step(1, 6, 0, 0);
        check("post_flush_dup", int'(dup_drop), 0);
        check("post_flush_min", int'(eng2uca_min), 6);
        step(0, 0, 1, 0);

        // Asynchronous reset between edges
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        step(1, -1, 0, 0);
        check("pre_rst_count", int'(count), 4);
        check("pre_rst_conflict", int'(local_conflict), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_conflict", int'(local_conflict), 0);
        check("arst_empty", int'(eng2uca_empty), 1);
        check("arst_min", int'(eng2uca_min), 0);
        check("arst_valid", int'(eng2uca_valid), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 2, 0, 0);
        check("post_rst_min", int'(eng2uca_min), 2);
        check("post_rst_count", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
